// File: rtl/simon_iter_core.sv
// simon_iter_core -- iterative Simon block cipher core (encrypt only).
//
// Computes the T-round Simon encryption of one 2N-bit block with an
// M-word key. The key schedule runs on the fly in an M-word shift register;
// no round-key table is stored.
//
// Parameters
//   N : word size, 16 / 24 / 32
//   M : key words; legal (N,M): (16,4) (24,3) (24,4) (32,3) (32,4)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : plaintext/key valid (sampled in IDLE only)
//   in_ready   : core idle and able to accept a block
//   plaintext  : {x, y}, x in the upper word
//   key        : {k[M-1], ..., k[0]}, k[0] in the lowest word
//   out_valid  : ciphertext valid (DONE state)
//   out_ready  : consumer takes the ciphertext
//   ciphertext : {x, y} after the last round, held until taken
//   busy       : rounds in progress
//
// Build option
//   SIMON_ROUNDS2_EN : two rounds and two key-schedule steps per cycle
//                      (latency T/2). Ciphertext is unchanged.

module simon_iter_core #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   plaintext,
    input  logic [M*N-1:0]   key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   ciphertext,
    output logic             busy
);

    localparam bit LEGAL = (N == 16 && M == 4) ||
                           (N == 24 && (M == 3 || M == 4)) ||
                           (N == 32 && (M == 3 || M == 4));

    localparam int T  = (N == 16) ? 32 : (N == 24) ? 36 : (M == 3) ? 42 : 44;
    localparam int CW = $clog2(T);

    generate
        if (!LEGAL) begin : g_illegal
            $error("simon_iter_core: unsupported (N,M) parameter pair");
        end
    endgenerate

`ifdef SIMON_ROUNDS2_EN
    localparam int RPC = 2;
`else
    localparam int RPC = 1;
`endif

    // Counter holds the index of the first round done this cycle; it stops
    // at LAST rather than wrapping.
    localparam logic [CW-1:0] LAST = CW'(T - RPC);
    localparam logic [CW-1:0] STEP = CW'(RPC);

    // z sequences written as z[0] first (MSB), so z[i] = Zx[61-i].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    localparam logic [61:0] ZSEQ = (N == 16)            ? Z0 :
                                   (N == 24 && M == 3)  ? Z0 :
                                   (N == 24)            ? Z1 :
                                   (M == 3)             ? Z2 : Z3;

    typedef logic [M-1:0][N-1:0] kreg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

    function automatic logic [2*N-1:0] round_f(input logic [2*N-1:0] xy, input logic [N-1:0] k);
        logic [N-1:0] x;
        logic [N-1:0] y;
        x = xy[2*N-1:N];
        y = xy[N-1:0];
        return {y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ k, x};
    endfunction

    // One key-schedule step: k[0] is the key used this round, the result
    // is the register shifted down one word with k[i+M] entering on top.
    // T <= 44 < 62, so the z index never needs the mod-62 fold.
    function automatic kreg_t key_step(input kreg_t k, input logic [5:0] i);
        logic [N-1:0] tmp;
        logic [N-1:0] knew;
        tmp = rotr(k[M-1], 3);
        if (M == 4) tmp = tmp ^ k[1];
        tmp = tmp ^ rotr(tmp, 1);
        knew = ~k[0] ^ tmp ^ {{(N-1){1'b0}}, ZSEQ[6'd61 - i]} ^ {{(N-2){1'b0}}, 2'b11};
        return {knew, k[M-1:1]};
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [2*N-1:0]  xy_q,    xy_d;
    kreg_t           k_q,     k_d;
    logic [2*N-1:0]  ct_q,    ct_d;

    logic [2*N-1:0]  xy_r;
    kreg_t           k_r;
    logic [5:0]      zi;

    assign zi = 6'(cnt_q);

    // Round datapath for the current cycle.
    always_comb begin
`ifdef SIMON_ROUNDS2_EN
        xy_r = round_f(round_f(xy_q, k_q[0]), k_q[1]);
        k_r  = key_step(key_step(k_q, zi), zi + 6'd1);
`else
        xy_r = round_f(xy_q, k_q[0]);
        k_r  = key_step(k_q, zi);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xy_d    = xy_q;
        k_d     = k_q;
        ct_d    = ct_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xy_d    = plaintext;
                    k_d     = key;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                xy_d = xy_r;
                k_d  = k_r;
                if (cnt_q == LAST) begin
                    ct_d    = xy_r;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + STEP;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xy_q    <= '0;
            k_q     <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xy_q    <= xy_d;
            k_q     <= k_d;
            ct_q    <= ct_d;
        end
    end

    // Gated by reset so the core never advertises readiness while held in reset.
    assign in_ready   = (state_q == IDLE) && reset;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// Testbench for simon_iter_core: directed known-answer vectors for three
// parameter sets, DONE hold / back-pressure, mid-block reset, and a random
// stream on the (16,4) core checked every cycle against a behavioural model.

module tb_simon_iter_core;

`ifdef SIMON_ROUNDS2_EN
    localparam int TL16 = 16;
    localparam int TL24 = 18;
    localparam int TL32 = 22;
`else
    localparam int TL16 = 32;
    localparam int TL24 = 36;
    localparam int TL32 = 44;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv16, ir16, ov16, or16, busy16;
    logic [31:0] pt16, ct16;
    logic [63:0] key16;

    logic        iv24, ir24, ov24, or24, busy24;
    logic [47:0] pt24, ct24;
    logic [71:0] key24;

    logic         iv32, ir32, ov32, or32, busy32;
    logic [63:0]  pt32, ct32;
    logic [127:0] key32;

    simon_iter_core #(.N(16), .M(4)) u16 (
        .clk(clk), .reset(rst_n), .in_valid(iv16), .in_ready(ir16),
        .plaintext(pt16), .key(key16), .out_valid(ov16), .out_ready(or16),
        .ciphertext(ct16), .busy(busy16));

    simon_iter_core #(.N(24), .M(3)) u24 (
        .clk(clk), .reset(rst_n), .in_valid(iv24), .in_ready(ir24),
        .plaintext(pt24), .key(key24), .out_valid(ov24), .out_ready(or24),
        .ciphertext(ct24), .busy(busy24));

    simon_iter_core #(.N(32), .M(4)) u32 (
        .clk(clk), .reset(rst_n), .in_valid(iv32), .in_ready(ir32),
        .plaintext(pt32), .key(key32), .out_valid(ov32), .out_ready(or32),
        .ciphertext(ct32), .busy(busy32));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] wmask(input int n);
        return (n == 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic logic [31:0] m_rotl(input logic [31:0] v, input int s, input int n);
        return ((v << s) | (v >> (n - s))) & wmask(n);
    endfunction

    function automatic logic [31:0] m_rotr(input logic [31:0] v, input int s, input int n);
        return ((v >> s) | (v << (n - s))) & wmask(n);
    endfunction

    // Expands the full round-key list first, then runs the rounds.
    function automatic logic [63:0] simon_ref(input int n, input int m,
                                              input logic [63:0] pt, input logic [127:0] key);
        string       zs;
        int          t;
        logic [31:0] mask, x, y, tx, tmp, zb;
        logic [31:0] k [0:63];
        mask = wmask(n);
        if (n == 16) begin
            t = 32; zs = "11111010001001010110000111001101111101000100101011000011100110";
        end else if (n == 24 && m == 3) begin
            t = 36; zs = "11111010001001010110000111001101111101000100101011000011100110";
        end else if (n == 24) begin
            t = 36; zs = "10001110111110010011000010110101000111011111001001100001011010";
        end else if (m == 3) begin
            t = 42; zs = "10101111011100000011010010011000101000010001111110010110110011";
        end else begin
            t = 44; zs = "11011011101011000110010111100000010010001010011100110100001111";
        end
        for (int i = 0; i < m; i++) k[i] = 32'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = m_rotr(k[i-1], 3, n);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp = tmp ^ m_rotr(tmp, 1, n);
            zb  = (zs.getc((i - m) % 62) == "1") ? 32'd1 : 32'd0;
            k[i] = (mask ^ 32'd3) ^ zb ^ k[i-m] ^ tmp;
        end
        x = 32'(pt >> n) & mask;
        y = 32'(pt) & mask;
        for (int i = 0; i < t; i++) begin
            tx = x;
            x  = (y ^ (m_rotl(x, 1, n) & m_rotl(x, 8, n)) ^ m_rotl(x, 2, n) ^ k[i]) & mask;
            y  = tx;
        end
        return (64'(x) << n) | 64'(y);
    endfunction

    // ---------------- per-cycle compare on the (16,4) core ----------------
    bit          pend = 1'b0;
    int          age  = 0;
    logic [63:0] exp_ct = '0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst in_ready", 64'(ir16), 64'd0);
            check("rst out_valid", 64'(ov16), 64'd0);
            check("rst busy", 64'(busy16), 64'd0);
            check("rst ciphertext", 64'(ct16), 64'd0);
            pend = 1'b0;
        end else begin
            check("cyc in_ready", 64'(ir16), 64'(!pend));
            check("cyc busy", 64'(busy16), 64'(pend && age < TL16));
            check("cyc out_valid", 64'(ov16), 64'(pend && age >= TL16));
            if (pend && age >= TL16) check("cyc ciphertext", 64'(ct16), exp_ct);
            if (pend) begin
                if (age >= TL16 && or16) begin
                    pend = 1'b0;
                    n_done++;
                end else begin
                    age++;
                end
            end else if (iv16) begin
                pend   = 1'b1;
                age    = 0;
                exp_ct = simon_ref(16, 4, 64'(pt16), 128'(key16));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input logic [31:0] pt, input logic [63:0] key, input logic [31:0] exp,
                         input int hold, input string tag);
        int lat;
        pt16 = pt; key16 = key; iv16 = 1'b1; or16 = 1'b0;
        tick();
        iv16 = 1'b0; pt16 = $urandom; key16 = {$urandom, $urandom};
        lat = 0;
        while (!ov16 && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(TL16));
        check({tag, " ct"}, 64'(ct16), 64'(exp));
        for (int h = 0; h < hold; h++) begin
            iv16 = 1'b1; pt16 = $urandom; key16 = {$urandom, $urandom};
            tick();
            check({tag, " hold out_valid"}, 64'(ov16), 64'd1);
            check({tag, " hold in_ready"}, 64'(ir16), 64'd0);
            check({tag, " hold ct"}, 64'(ct16), 64'(exp));
        end
        iv16 = 1'b0; or16 = 1'b1;
        tick();
        or16 = 1'b0;
        check({tag, " drain out_valid"}, 64'(ov16), 64'd0);
        check({tag, " drain in_ready"}, 64'(ir16), 64'd1);
    endtask

    task automatic run_wide(input int which, input logic [63:0] pt, input logic [127:0] key,
                            input logic [63:0] exp, input string tag);
        int          lat, tl;
        logic [63:0] got, mdl;
        tl = (which == 24) ? TL24 : TL32;
        if (which == 24) begin
            pt24 = pt[47:0]; key24 = key[71:0]; iv24 = 1'b1;
            mdl  = simon_ref(24, 3, pt, key);
        end else begin
            pt32 = pt; key32 = key; iv32 = 1'b1;
            mdl  = simon_ref(32, 4, pt, key);
        end
        tick();
        iv24 = 1'b0; iv32 = 1'b0;
        lat = 0;
        while (!((which == 24) ? ov24 : ov32) && lat < 200) begin
            tick();
            lat++;
        end
        got = (which == 24) ? 64'(ct24) : ct32;
        check({tag, " latency"}, 64'(lat), 64'(tl));
        check({tag, " ct"}, got, exp);
        check({tag, " ct vs model"}, got, mdl);
        or24 = 1'b1; or32 = 1'b1;
        tick();
        or24 = 1'b0; or32 = 1'b0;
        check({tag, " drain out_valid"}, 64'((which == 24) ? ov24 : ov32), 64'd0);
    endtask

    initial begin
        int          base, cyc;
        logic [63:0] rp;
        logic [127:0] rk;
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; pt16 = '0; key16 = '0;
        iv24 = 0; or24 = 0; pt24 = '0; key24 = '0;
        iv32 = 0; or32 = 0; pt32 = '0; key32 = '0;
        repeat (3) tick();
        check("reset u24 in_ready", 64'(ir24), 64'd0);
        check("reset u24 ct", 64'(ct24), 64'd0);
        check("reset u32 busy", 64'(busy32), 64'd0);
        check("reset u32 out_valid", 64'(ov32), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset u16 in_ready", 64'(ir16), 64'd1);
        check("post-reset u32 in_ready", 64'(ir32), 64'd1);

        // Known-answer vectors
        run16(32'h6565_6877, 64'h1918_1110_0908_0100, 32'hc69b_e9bb, 0, "kat16");
        run_wide(24, 64'h6120_676e_696c, 128'h12_1110_0a09_0802_0100, 64'hdae5_ac29_2cac, "kat24");
        run_wide(32, 64'h656b_696c_2064_6e75, 128'h1b1a_1918_1312_1110_0b0a_0908_0302_0100,
                 64'h44c8_fc20_b9df_a07a, "kat32");

        // DONE held 10 cycles with competing in_valid
        run16(32'h6565_6877, 64'h1918_1110_0908_0100, 32'hc69b_e9bb, 10, "hold16");

        // Reset during round 10, then rerun
        pt16 = 32'h6565_6877; key16 = 64'h1918_1110_0908_0100; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        repeat (10) tick();
        check("midrun busy before reset", 64'(busy16), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(ir16), 64'd0);
        check("abort out_valid", 64'(ov16), 64'd0);
        check("abort busy", 64'(busy16), 64'd0);
        check("abort ct", 64'(ct16), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run16(32'h6565_6877, 64'h1918_1110_0908_0100, 32'hc69b_e9bb, 0, "rerun16");

        // A few random blocks on the wider cores
        for (int i = 0; i < 3; i++) begin
            rp = {$urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_wide(24, 64'(rp[47:0]), 128'(rk[71:0]), simon_ref(24, 3, 64'(rp[47:0]), 128'(rk[71:0])), "rnd24");
            run_wide(32, rp, rk, simon_ref(32, 4, rp, rk), "rnd32");
        end

        // Random stream with back-pressure, checked by the compare process
        base = n_done;
        cyc  = 0;
        while ((n_done - base) < 1000 && cyc < 80000) begin
            iv16  = ($urandom_range(0, 3) != 0);
            pt16  = $urandom;
            key16 = {$urandom, $urandom};
            or16  = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("stream blocks completed", 64'(n_done - base), 64'd1000);
        iv16 = 1'b0; or16 = 1'b1;
        repeat (TL16 + 4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, %0d of %0d checks failed so far", n_fail, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simon_iter_core.md
SIMON_ITER_CORE -- requirements
Module: simon_iter_core

Interface
REQ-001 Parameter N, default 16, meaning word size in bits; legal values 16, 24, 32.
REQ-002 Parameter M, default 4, meaning key words; legal (N,M) pairs are (16,4), (24,3), (24,4), (32,3) and (32,4).
REQ-003 Port clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  plaintext and key are valid.
REQ-006 Port in_ready  output  1  core accepts a new block this cycle.
REQ-007 Port plaintext  input  2N  block; x = plaintext[2N-1:N], y = plaintext[N-1:0].
REQ-008 Port key  input  M*N  key; k[M-1] = key[M*N-1 -: N] through k[0] = key[N-1:0].
REQ-009 Port out_valid  output  1  ciphertext is valid.
REQ-010 Port out_ready  input  1  consumer takes the ciphertext.
REQ-011 Port ciphertext  output  2N  result, packed the same way as plaintext.
REQ-012 Port busy  output  1  high in RUN state.

Function
REQ-013 The block SHALL implement Simon encryption with T rounds: T = 32, 36, 36, 42, 44 and z-sequence z0, z0, z1, z2, z3 for (16,4), (24,3), (24,4), (32,3), (32,4) respectively.
REQ-014 Round: x' = y ^ ((x<<<1) & (x<<<8)) ^ (x<<<2) ^ k_i; y' = x.
REQ-015 Key expansion SHALL run on the fly in an M-word shift register, with no stored round-key table.
REQ-016 For M=4: tmp = (k[i+3]>>>3) ^ k[i+1], then tmp ^= tmp>>>1, then k[i+4] = ~k[i] ^ tmp ^ z[(i) mod 62] ^ 3.
REQ-017 For M=3: tmp = (k[i+2]>>>3), then tmp ^= tmp>>>1, then k[i+3] = ~k[i] ^ tmp ^ z[(i) mod 62] ^ 3.
REQ-018 All arithmetic SHALL be modulo 2^N; rotations are N-bit circular.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE: in_ready=1; on in_valid the block SHALL latch plaintext and key, clear the round counter and go to RUN.
REQ-021 RUN: in_ready=0, busy=1; one round per cycle; after round T-1 the block SHALL load the ciphertext register and go to DONE.
REQ-022 Latency: out_valid SHALL rise exactly T cycles after the accepting edge.
REQ-023 DONE: out_valid=1 and ciphertext is held stable; when out_ready=1 the FSM SHALL go to IDLE, and out_valid SHALL drop on the next edge.
REQ-024 in_valid SHALL be ignored outside IDLE, so input changes during RUN or DONE have no effect.
REQ-025 Round counter width SHALL be ceil(log2(T)) bits; it SHALL NOT wrap within a block.
REQ-026 Back-to-back throughput: one block per T+2 cycles when out_ready is held high.
REQ-027 An illegal (N,M) pair SHALL cause an elaboration-time error.

Reset
REQ-028 With reset=0, asynchronously: FSM=IDLE, counter=0, in_ready=0 while reset is asserted, then 1; out_valid=0; busy=0; ciphertext=0; data and key registers=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort the block; no partial result is ever presented.

Configuration
REQ-030 Macro SIMON_ROUNDS2_EN: when defined, the core SHALL compute two rounds and two key-schedule steps per cycle, with latency T/2 and throughput T/2+2 cycles per block; when undefined, it computes one round per cycle per REQ-021 and REQ-022. Ciphertext SHALL be identical in both builds.

Verification
REQ-031 N=16, M=4, key=1918_1110_0908_0100, pt=6565_6877 -> ct=c69b_e9bb, out_valid 32 cycles after accept (16 with SIMON_ROUNDS2_EN).
REQ-032 N=24, M=3, key=121110_0a0908_020100, pt=612067_6e696c -> ct=dae5ac_292cac after 36 cycles.
REQ-033 N=32, M=4, key=1b1a1918_13121110_0b0a0908_03020100, pt=656b696c_20646e75 -> ct=44c8fc20_b9dfa07a after 44 cycles.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> ciphertext and out_valid stable, in_ready=0, new in_valid ignored; then raise out_ready -> IDLE next cycle.
REQ-035 Assert reset at round 10 of the REQ-031 vector -> all outputs 0 immediately; re-run the vector -> correct ct with the same latency.
REQ-036 Stream 1000 random blocks against a reference model with random out_ready back-pressure -> zero mismatches, no lost or duplicated outputs.
